morse_key_decoder: RTL and testbench

//  Front end of the Morse translator: turns a telegraph key and three buttons into
//  the character/command stream consumed by the text LCD controller.
//  - Debounces inputs and times key presses/releases against a dot unit.
//  - Assembles dot/dash symbols and decodes them to uppercase ASCII.
//  - Emits one-cycle pulses: char_valid, transfer_to_row1, clear_out.

---
 rtl/morse_key_decoder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_morse_key_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder
// Brief    : Debounces a telegraph key and three buttons, times key presses
//            against a Morse unit and emits decoded ASCII plus LCD commands.
//            Define MORSE_PUNCT_EN for a 6-symbol buffer with . , ? decodes.
// Revision : 1.0  initial release
// ============================================================================
module morse_key_decoder #(
    parameter int UNIT_CYC     = 100000,
    parameter int DEBOUNCE_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    input  logic       btn_row_in,
    input  logic       btn_transfer_in,
    input  logic       btn_clear_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       char_to_row2,
    output logic       transfer_to_row1,
    output logic       clear_out
);

`ifdef MORSE_PUNCT_EN
    localparam int c_MAX_LEN = 6;
`else
    localparam int c_MAX_LEN = 5;
`endif
    localparam int                c_DB_W        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST     = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [19:0]       c_DOT_LIMIT   = 20'(2 * UNIT_CYC);
    localparam logic [19:0]       c_LETTER_LAST = 20'(3 * UNIT_CYC - 1);
    localparam logic [19:0]       c_WORD_LAST   = 20'(7 * UNIT_CYC - 1);
    localparam logic [2:0]        c_LEN_FULL    = 3'(c_MAX_LEN);
    localparam logic [7:0]        c_SPACE       = 8'h20;
    localparam logic [7:0]        c_STAR        = 8'h2A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
        S_EMIT  = 3'd3,
        S_WORD  = 3'd4,
        S_SPACE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 key, 1 row, 2 transfer, 3 clear
    // ------------------------------------------------------------------
    logic [3:0] w_raw;
    logic [3:0] w_deb;
    logic [3:0] r_deb_d;
    logic [3:0] w_rise;

    assign w_raw = {btn_clear_in, btn_transfer_in, btn_row_in, key_in};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_cond
            logic [1:0]        r_sync;
            logic [c_DB_W-1:0] r_cnt;
            logic              r_level;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync  <= 2'b00;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[i]};
                    // Any bounce back to the accepted level restarts the stability window.
                    if (r_sync[1] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_level <= r_sync[1];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[i] = r_level;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_deb_d <= 4'b0000;
        else        r_deb_d <= w_deb;
    end

    assign w_rise = w_deb & ~r_deb_d;

    logic w_key_rise, w_key_fall, w_row_rise, w_tr_rise, w_clr_rise;
    assign w_key_rise = w_rise[0];
    assign w_key_fall = ~w_deb[0] & r_deb_d[0];
    assign w_row_rise = w_rise[1];
    assign w_tr_rise  = w_rise[2];
    assign w_clr_rise = w_rise[3];

    // ------------------------------------------------------------------
    // Press / release duration, restarted on every key edge
    // ------------------------------------------------------------------
    logic [19:0] r_dur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_dur <= '0;
        else if (w_key_rise | w_key_fall) r_dur <= '0;
        else if (r_dur != '1)             r_dur <= r_dur + 20'd1;
    end

    // ------------------------------------------------------------------
    // Symbol buffer and decode; symbols shift in at the LSB
    // ------------------------------------------------------------------
    logic [2:0] r_len;
    logic [5:0] r_bits;
    logic       r_ovf;
    logic       w_is_dash;
    logic [7:0] w_decoded;

    function automatic logic [7:0] f_decode(input logic [2:0] len, input logic [5:0] bits);
        logic [7:0] ch;
        case ({len, bits})
            {3'd2, 6'b000001}: ch = 8'h41; // A
            {3'd4, 6'b001000}: ch = 8'h42; // B
            {3'd4, 6'b001010}: ch = 8'h43; // C
            {3'd3, 6'b000100}: ch = 8'h44; // D
            {3'd1, 6'b000000}: ch = 8'h45; // E
            {3'd4, 6'b000010}: ch = 8'h46; // F
            {3'd3, 6'b000110}: ch = 8'h47; // G
            {3'd4, 6'b000000}: ch = 8'h48; // H
            {3'd2, 6'b000000}: ch = 8'h49; // I
            {3'd4, 6'b000111}: ch = 8'h4A; // J
            {3'd3, 6'b000101}: ch = 8'h4B; // K
            {3'd4, 6'b000100}: ch = 8'h4C; // L
            {3'd2, 6'b000011}: ch = 8'h4D; // M
            {3'd2, 6'b000010}: ch = 8'h4E; // N
            {3'd3, 6'b000111}: ch = 8'h4F; // O
            {3'd4, 6'b000110}: ch = 8'h50; // P
            {3'd4, 6'b001101}: ch = 8'h51; // Q
            {3'd3, 6'b000010}: ch = 8'h52; // R
            {3'd3, 6'b000000}: ch = 8'h53; // S
            {3'd1, 6'b000001}: ch = 8'h54; // T
            {3'd3, 6'b000001}: ch = 8'h55; // U
            {3'd4, 6'b000001}: ch = 8'h56; // V
            {3'd3, 6'b000011}: ch = 8'h57; // W
            {3'd4, 6'b001001}: ch = 8'h58; // X
            {3'd4, 6'b001011}: ch = 8'h59; // Y
            {3'd4, 6'b001100}: ch = 8'h5A; // Z
            {3'd5, 6'b011111}: ch = 8'h30;
            {3'd5, 6'b001111}: ch = 8'h31;
            {3'd5, 6'b000111}: ch = 8'h32;
            {3'd5, 6'b000011}: ch = 8'h33;
            {3'd5, 6'b000001}: ch = 8'h34;
            {3'd5, 6'b000000}: ch = 8'h35;
            {3'd5, 6'b010000}: ch = 8'h36;
            {3'd5, 6'b011000}: ch = 8'h37;
            {3'd5, 6'b011100}: ch = 8'h38;
            {3'd5, 6'b011110}: ch = 8'h39;
`ifdef MORSE_PUNCT_EN
            {3'd6, 6'b010101}: ch = 8'h2E;
            {3'd6, 6'b110011}: ch = 8'h2C;
            {3'd6, 6'b001100}: ch = 8'h3F;
`endif
            default:           ch = c_STAR;
        endcase
        return ch;
    endfunction

    assign w_is_dash = (r_dur >= c_DOT_LIMIT);
    assign w_decoded = r_ovf ? c_STAR : f_decode(r_len, r_bits);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nxt;
    logic       w_fire;
    logic [7:0] w_fire_char;
    logic       w_buf_clr;
    logic       w_append;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_fire_char = c_SPACE;
        w_buf_clr   = 1'b0;
        w_append    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_key_rise) w_state_nxt = S_PRESS;
            end
            S_PRESS: begin
                if (w_key_fall) begin
                    w_append    = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            // Leaving one count early puts char_valid right after the count hits 3 units.
            S_GAP: begin
                if (w_key_rise)                  w_state_nxt = S_PRESS;
                else if (r_dur == c_LETTER_LAST) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (!w_tr_rise) begin
                    w_fire      = 1'b1;
                    w_fire_char = w_decoded;
                    w_buf_clr   = 1'b1;
                    w_state_nxt = w_key_rise ? S_PRESS : S_WORD;
                end
            end
            S_WORD: begin
                if (w_key_rise)                w_state_nxt = S_PRESS;
                else if (r_dur == c_WORD_LAST) w_state_nxt = S_SPACE;
            end
            S_SPACE: begin
                if (!w_tr_rise) begin
                    w_fire      = 1'b1;
                    w_fire_char = c_SPACE;
                    w_state_nxt = w_key_rise ? S_PRESS : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_clr_rise) begin
            w_state_nxt = S_IDLE;
            w_fire      = 1'b0;
            w_buf_clr   = 1'b1;
            w_append    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= 3'd0;
            r_bits <= 6'd0;
            r_ovf  <= 1'b0;
        end else if (w_buf_clr) begin
            r_len  <= 3'd0;
            r_bits <= 6'd0;
            r_ovf  <= 1'b0;
        end else if (w_append) begin
            if (r_len == c_LEN_FULL) begin
                r_ovf <= 1'b1;
            end else begin
                r_bits <= {r_bits[4:0], w_is_dash};
                r_len  <= r_len + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [7:0] r_char_out;
    logic       r_char_valid, r_row2, r_transfer, r_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_out   <= c_SPACE;
            r_char_valid <= 1'b0;
            r_row2       <= 1'b0;
            r_transfer   <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            r_char_valid <= w_fire;
            r_transfer   <= w_tr_rise & ~w_clr_rise;
            r_clear      <= w_clr_rise;
            if (w_fire) r_char_out <= w_fire_char;
            if (w_clr_rise)      r_row2 <= 1'b0;
            else if (w_tr_rise)  r_row2 <= 1'b1;
            else if (w_row_rise) r_row2 <= ~r_row2;
        end
    end

    assign char_out         = r_char_out;
    assign char_valid       = r_char_valid;
    assign char_to_row2     = r_row2;
    assign transfer_to_row1 = r_transfer;
    assign clear_out        = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_key_decoder
// Brief    : Directed vector bench for morse_key_decoder (UNIT 100, DEBOUNCE 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_morse_key_decoder;
    localparam int c_UNIT = 100;
    localparam int c_DEB  = 4;
    localparam int c_NVEC = 11;

    logic       clk             = 1'b0;
    logic       rst_n           = 1'b0;
    logic       key_in          = 1'b0;
    logic       btn_row_in      = 1'b0;
    logic       btn_transfer_in = 1'b0;
    logic       btn_clear_in    = 1'b0;
    logic [7:0] char_out;
    logic       char_valid, char_to_row2, transfer_to_row1, clear_out;

    always #5 clk = ~clk;

    morse_key_decoder #(
        .UNIT_CYC    (c_UNIT),
        .DEBOUNCE_CYC(c_DEB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_in          (key_in),
        .btn_row_in      (btn_row_in),
        .btn_transfer_in (btn_transfer_in),
        .btn_clear_in    (btn_clear_in),
        .char_out        (char_out),
        .char_valid      (char_valid),
        .char_to_row2    (char_to_row2),
        .transfer_to_row1(transfer_to_row1),
        .clear_out       (clear_out)
    );

    typedef struct {
        string      name;
        int         len;
        logic [5:0] bits;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [c_NVEC];

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_tr     = 0;
    int         n_clr    = 0;
    int         n_viol   = 0;
    int         tr_cyc   = -1;
    logic [7:0] ch_q [$];
    int         ch_cyc_q [$];
    logic       prev_cv  = 1'b0;
    logic       prev_tr  = 1'b0;
    logic       prev_clr = 1'b0;

    // Pulse recorder: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (char_valid) begin
                ch_q.push_back(char_out);
                ch_cyc_q.push_back(cyc);
            end
            if (transfer_to_row1) begin
                n_tr   = n_tr + 1;
                tr_cyc = cyc;
            end
            if (clear_out) n_clr = n_clr + 1;
            if (int'(char_valid) + int'(transfer_to_row1) + int'(clear_out) > 1) n_viol = n_viol + 1;
            if ((char_valid && prev_cv) || (transfer_to_row1 && prev_tr) || (clear_out && prev_clr))
                n_viol = n_viol + 1;
        end
        prev_cv  = char_valid;
        prev_tr  = transfer_to_row1;
        prev_clr = clear_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int n);
        key_in = 1'b1;
        wait_cyc(n);
        key_in = 1'b0;
    endtask

    task automatic send_char(input int len, input logic [5:0] bits);
        for (int i = len - 1; i >= 0; i--) begin
            press_key(bits[i] ? 3 * c_UNIT : c_UNIT);
            wait_cyc(c_UNIT);
        end
    endtask

    task automatic press_row();
        btn_row_in = 1'b1;
        wait_cyc(20);
        btn_row_in = 1'b0;
        wait_cyc(20);
    endtask

    int base, tr0, clr0;

    initial begin
        vecs[0]  = '{"A",      2, 6'b000001, 8'h41};
        vecs[1]  = '{"E",      1, 6'b000000, 8'h45};
        vecs[2]  = '{"T",      1, 6'b000001, 8'h54};
        vecs[3]  = '{"Q",      4, 6'b001101, 8'h51};
        vecs[4]  = '{"S",      3, 6'b000000, 8'h53};
        vecs[5]  = '{"5",      5, 6'b000000, 8'h35};
        vecs[6]  = '{"9",      5, 6'b011110, 8'h39};
        vecs[7]  = '{"dashx4", 4, 6'b001111, 8'h2A};
        vecs[8]  = '{"dotx6",  6, 6'b000000, 8'h2A};
`ifdef MORSE_PUNCT_EN
        vecs[9]  = '{"period", 6, 6'b010101, 8'h2E};
`else
        vecs[9]  = '{"period", 6, 6'b010101, 8'h2A};
`endif
        vecs[10] = '{"0",      5, 6'b011111, 8'h30};

        wait_cyc(5);
        check("reset char_out", {24'd0, char_out}, 32'h20);
        check("reset flags", {28'd0, char_valid, char_to_row2, transfer_to_row1, clear_out}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Table of characters, each started before the word gap expires.
        for (int v = 0; v < c_NVEC; v++) begin
            base = ch_q.size();
            send_char(vecs[v].len, vecs[v].bits);
            wait_cyc(350);
            check({vecs[v].name, " count"}, ch_q.size() - base, 1);
            if (ch_q.size() > base) check(vecs[v].name, {24'd0, ch_q[base]}, {24'd0, vecs[v].exp});
        end

        base = ch_q.size();
        wait_cyc(500);
        check("word space count", ch_q.size() - base, 1);
        if (ch_q.size() > base) check("word space", {24'd0, ch_q[base]}, 32'h20);

        base = ch_q.size(); tr0 = n_tr; clr0 = n_clr;
        wait_cyc(2000);
        check("idle chars", ch_q.size() - base, 0);
        check("idle pulses", (n_tr - tr0) + (n_clr - clr0), 0);

        press_row();
        check("row toggle on", {31'd0, char_to_row2}, 1);
        press_row();
        check("row toggle off", {31'd0, char_to_row2}, 0);

        // Transfer lands on the EMIT cycle: debounced edges share the same pipeline delay.
        base = ch_q.size(); tr0 = n_tr;
        press_key(c_UNIT);
        wait_cyc(c_UNIT);
        press_key(3 * c_UNIT);
        wait_cyc(301);
        btn_transfer_in = 1'b1;
        wait_cyc(20);
        btn_transfer_in = 1'b0;
        wait_cyc(20);
        check("transfer count", n_tr - tr0, 1);
        check("held char count", ch_q.size() - base, 1);
        if (ch_q.size() > base) begin
            check("held char", {24'd0, ch_q[base]}, 32'h41);
            check("char after transfer", ch_cyc_q[base] - tr_cyc, 1);
        end
        check("transfer row2", {31'd0, char_to_row2}, 1);

        // Reset asserted in the middle of a key press.
        key_in = 1'b1;
        wait_cyc(50);
        rst_n = 1'b0;
        #1;
        check("midpress char_out", {24'd0, char_out}, 32'h20);
        check("midpress flags", {28'd0, char_valid, char_to_row2, transfer_to_row1, clear_out}, 32'h0);
        key_in = 1'b0;
        wait_cyc(10);
        rst_n = 1'b1;
        base = ch_q.size(); tr0 = n_tr; clr0 = n_clr;
        wait_cyc(1000);
        check("post reset chars", ch_q.size() - base, 0);
        check("post reset pulses", (n_tr - tr0) + (n_clr - clr0), 0);

        // Clear while two symbols are pending in the letter gap.
        press_row();
        check("row before clear", {31'd0, char_to_row2}, 1);
        base = ch_q.size(); clr0 = n_clr;
        press_key(c_UNIT);
        wait_cyc(c_UNIT);
        press_key(c_UNIT);
        wait_cyc(c_UNIT);
        btn_clear_in = 1'b1;
        wait_cyc(20);
        btn_clear_in = 1'b0;
        wait_cyc(1000);
        check("clear count", n_clr - clr0, 1);
        check("clear drops char", ch_q.size() - base, 0);
        check("clear row2", {31'd0, char_to_row2}, 0);

        base = ch_q.size();
        send_char(1, 6'b000000);
        wait_cyc(350);
        check("fresh char count", ch_q.size() - base, 1);
        if (ch_q.size() > base) check("fresh char", {24'd0, ch_q[base]}, 32'h45);

        check("pulse rules", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
